// File: rtl/imem_if.sv
// Fetch request / response handshake bundle between a core front end (master)
// and an instruction store (slave).
interface imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: a preloadable word store that answers fetches after a
// fixed delay pipe, through a credit-limited, strictly in-order response queue.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QDEPTH      = 4,
  localparam int unsigned IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  imem_if.slave           bus,
  input  logic            load_en,
  input  logic [IDXW-1:0] load_idx,
  input  logic [31:0]     load_data
);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [63:0] END_ADDR = BASE_ADDR + (64'(DEPTH_WORDS) << 2);

  logic [31:0]        store_q [DEPTH_WORDS];
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [31:0]        pipe_inst_q [LATENCY];
  logic [LATENCY-1:0] pipe_err_q;
  logic [31:0]        fifo_inst_q [QDEPTH];
  logic [QDEPTH-1:0]  fifo_err_q;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d, outst_q, outst_d;

  logic [63:0]        offset_s;
  logic [IDXW-1:0]    rd_idx_s;
  logic               addr_err_s;
  logic [31:0]        rd_inst_s;
  logic               req_ready_s, accept_s, resp_valid_s, retire_s, push_s;

  // Address decode, handshakes and next-state for pipe valids, queue and credits.
  always_comb begin
    offset_s   = bus.req_addr - BASE_ADDR;
    rd_idx_s   = offset_s[IDXW+1:2];
    addr_err_s = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
                 (bus.req_addr >= END_ADDR);
    if (addr_err_s) begin
      rd_inst_s = 32'h0;
    end else begin
      rd_inst_s = store_q[rd_idx_s];
    end

    // Credits cover both the pipe and the queue, so a push can never find the queue full.
    req_ready_s  = !rst && (outst_q < CW'(QDEPTH));
    accept_s     = bus.req_valid && req_ready_s;
    resp_valid_s = (count_q != '0);
    retire_s     = resp_valid_s && bus.resp_ready;
    push_s       = pipe_vld_q[LATENCY-1];

    pipe_vld_d    = '0;
    pipe_vld_d[0] = accept_s;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (retire_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, retire_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({accept_s, retire_s})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Control state; reset empties the pipe and queue and returns all credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
    end
  end

  // Payload storage: kept out of reset so preloaded instructions survive rst.
  always_ff @(posedge clk) begin
    if (load_en) begin
      store_q[load_idx] <= load_data;
    end
    pipe_inst_q[0] <= rd_inst_s;
    pipe_err_q[0]  <= addr_err_s;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_inst_q[i] <= pipe_inst_q[i-1];
      pipe_err_q[i]  <= pipe_err_q[i-1];
    end
    if (push_s) begin
      fifo_inst_q[wr_ptr_q] <= pipe_inst_q[LATENCY-1];
      fifo_err_q[wr_ptr_q]  <= pipe_err_q[LATENCY-1];
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_inst  = resp_valid_s ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign bus.resp_err   = resp_valid_s ? fifo_err_q[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed vector table plus corner sequences,
// with a queue-based reference model watching every cycle.
module tb_imem_responder;
  localparam int unsigned DEPTH   = 1024;
  localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned QDEPTH  = 4;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_data;
  imem_if      bif ();

  imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bif),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          rdy;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mdl_mem [DEPTH];
  int          cyc = 0;

  function automatic exp_t model_read(input logic [63:0] a);
    exp_t        e;
    logic [63:0] lim;
    lim   = BASE + 64'(4 * DEPTH);
    e.rdy = 0;
    if (a[1:0] != 2'b00 || a < BASE || a >= lim) begin
      e.inst = 32'h0;
      e.err  = 1'b1;
    end else begin
      e.inst = mdl_mem[int'((a - BASE) >> 2)];
      e.err  = 1'b0;
    end
    return e;
  endfunction

  initial begin
    exp_t        pend;
    logic        pend_acc, pend_ret, pend_ld, exp_v;
    logic [9:0]  ld_idx;
    logic [31:0] ld_dat;
    forever begin
      @(negedge clk);
      pend_acc = 1'b0;
      pend_ret = 1'b0;
      pend_ld  = load_en;
      ld_idx   = load_idx;
      ld_dat   = load_data;
      if (rst) begin
        expq.delete();
      end else begin
        exp_v = (expq.size() > 0) && (expq[0].rdy <= cyc);
        chk1("mon_resp_valid", bif.resp_valid, exp_v);
        chk1("mon_req_ready", bif.req_ready, expq.size() < QDEPTH);
        if (exp_v && bif.resp_valid) begin
          chk32("mon_resp_inst", bif.resp_inst, expq[0].inst);
          chk1("mon_resp_err", bif.resp_err, expq[0].err);
        end
        pend_ret = exp_v && bif.resp_ready;
        pend_acc = bif.req_valid && (expq.size() < QDEPTH);
        pend     = model_read(bif.req_addr);
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
        expq.delete();
      end else begin
        if (pend_ret) void'(expq.pop_front());
        if (pend_acc) begin
          pend.rdy = cyc + LATENCY;
          expq.push_back(pend);
        end
      end
      if (pend_ld) mdl_mem[ld_idx] = ld_dat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request (optionally with a colliding load) into an empty responder and
  // checks the response appears exactly LATENCY+1 cycles after acceptance.
  task automatic do_single(input string name, input logic [63:0] addr, input logic ld,
                           input logic [9:0] ld_i, input logic [31:0] ld_d,
                           input logic [31:0] exp_inst, input logic exp_err);
    tick();
    bif.req_valid = 1'b1;
    bif.req_addr  = addr;
    load_en       = ld;
    load_idx      = ld_i;
    load_data     = ld_d;
    @(negedge clk);
    chk1({name, "_ready"}, bif.req_ready, 1'b1);
    tick();
    bif.req_valid = 1'b0;
    load_en       = 1'b0;
    for (int k = 1; k <= LATENCY + 1; k++) begin
      @(negedge clk);
      if (k <= LATENCY) begin
        chk1({name, "_early"}, bif.resp_valid, 1'b0);
      end else begin
        chk1({name, "_valid"}, bif.resp_valid, 1'b1);
        chk32({name, "_inst"}, bif.resp_inst, exp_inst);
        chk1({name, "_err"}, bif.resp_err, exp_err);
      end
    end
    tick();
  endtask

  function automatic logic [31:0] preload_word(input int i);
    if (i == 0) return 32'h0000_0413;
    else if (i == 3) return 32'h0000_0013;
    else if (i == DEPTH - 1) return 32'hDEAD_BEEF;
    else return 32'h1000_0000 | 32'(i);
  endfunction

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic        ld;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  initial begin
    vec_t        vecs[10];
    logic        rdy;
    int          k, acc_n, ret_n, c;
    logic [31:0] got[$];
    logic [31:0] wexp;

    vecs[0] = '{"word0",      64'h8000_0000, 1'b0, 10'd0, 32'h0,         32'h0000_0413, 1'b0};
    vecs[1] = '{"word1",      64'h8000_0004, 1'b0, 10'd0, 32'h0,         32'h1000_0001, 1'b0};
    vecs[2] = '{"last_word",  64'h8000_0FFC, 1'b0, 10'd0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{"misalign",   64'h8000_0002, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};
    vecs[4] = '{"below_base", 64'h7FFF_FFFC, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};
    vecs[5] = '{"past_end",   64'h8000_1000, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};
    vecs[6] = '{"high_bits",  64'h1_8000_0000, 1'b0, 10'd0, 32'h0,       32'h0,         1'b1};
    vecs[7] = '{"ld_collide", 64'h8000_000C, 1'b1, 10'd3, 32'hAAAA_0001, 32'h0000_0013, 1'b0};
    vecs[8] = '{"ld_after",   64'h8000_000C, 1'b0, 10'd0, 32'h0,         32'hAAAA_0001, 1'b0};
    vecs[9] = '{"misalign_hi",64'h8000_0FFF, 1'b0, 10'd0, 32'h0,         32'h0,         1'b1};

    rst = 1'b0; load_en = 1'b0; load_idx = '0; load_data = '0;
    bif.req_valid = 1'b0; bif.req_addr = '0; bif.resp_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_resp_valid", bif.resp_valid, 1'b0);
    chk1("rst_req_ready", bif.req_ready, 1'b0);
    chk1("rst_resp_err", bif.resp_err, 1'b0);
    chk32("rst_resp_inst", bif.resp_inst, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("release_ready", bif.req_ready, 1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      tick();
      load_en = 1'b1; load_idx = 10'(i); load_data = preload_word(i);
    end
    tick();
    load_en = 1'b0;
    bif.resp_ready = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_single(vecs[i].name, vecs[i].addr, vecs[i].ld, vecs[i].ld_idx, vecs[i].ld_data,
                vecs[i].inst, vecs[i].err);
    end

    // Back-pressure: fill to QDEPTH with the consumer stalled, then drain in order.
    tick();
    bif.resp_ready = 1'b0;
    k = 0;
    bif.req_valid = 1'b1;
    bif.req_addr  = BASE;
    for (c = 0; c < 20 && k < 4; c++) begin
      @(negedge clk);
      rdy = bif.req_ready;
      tick();
      if (rdy) begin
        k++;
        bif.req_addr = BASE + 64'(4 * k);
      end
    end
    chki("accepts_before_stall", k, 4);
    repeat (3) begin
      @(negedge clk);
      chk1("stall_ready_low", bif.req_ready, 1'b0);
    end
    tick();
    bif.resp_ready = 1'b1;
    for (c = 0; c < 40 && (k < 6 || got.size() < 6); c++) begin
      @(negedge clk);
      rdy = bif.req_ready;
      if (bif.resp_valid) got.push_back(bif.resp_inst);
      tick();
      if (rdy && k < 6) begin
        k++;
        if (k < 6) bif.req_addr = BASE + 64'(4 * k);
        else bif.req_valid = 1'b0;
      end
    end
    bif.req_valid = 1'b0;
    chki("words_4_5_accepted", k, 6);
    chki("drain_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      wexp = preload_word(i);
      if (i == 3) wexp = 32'hAAAA_0001;
      chk32($sformatf("drain_order_%0d", i), got[i], wexp);
    end

    // Reset with three requests outstanding.
    bif.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bif.req_valid = 1'b1;
      bif.req_addr  = BASE + 64'(4 * i);
      tick();
    end
    bif.req_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk1("pre_rst_valid", bif.resp_valid, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk1("rst_now_valid", bif.resp_valid, 1'b0);
    chk1("rst_now_ready", bif.req_ready, 1'b0);
    chk32("rst_now_inst", bif.resp_inst, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk1("rst_hold_valid", bif.resp_valid, 1'b0);
    end
    tick();
    rst = 1'b0;
    bif.resp_ready = 1'b1;
    @(negedge clk);
    chk1("post_rst_ready", bif.req_ready, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk1("no_stale_resp", bif.resp_valid, 1'b0);
    end
    do_single("store_kept", BASE, 1'b0, 10'd0, 32'h0, 32'h0000_0413, 1'b0);

    // Steady streaming: one accept and one retire every cycle.
    acc_n = 0; ret_n = 0;
    bif.resp_ready = 1'b1;
    bif.req_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bif.req_addr = BASE + 64'(4 * $urandom_range(0, 15));
      @(negedge clk);
      if (i >= 8) begin
        chk1("stream_resp_valid", bif.resp_valid, 1'b1);
        chk1("stream_req_ready", bif.req_ready, 1'b1);
        if (bif.req_ready) acc_n++;
        if (bif.resp_valid) ret_n++;
      end
      tick();
    end
    chki("stream_balance", acc_n - ret_n, 0);
    chki("stream_rate", ret_n, 32);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bif.req_valid  = ($urandom % 4) != 0;
      bif.resp_ready = ($urandom % 3) != 0;
      load_en        = ($urandom % 5) == 0;
      load_idx       = 10'($urandom_range(0, 7));
      load_data      = $urandom;
      case ($urandom % 6)
        0: bif.req_addr = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
        1: bif.req_addr = BASE + 64'(4 * $urandom_range(0, 7)) + 64'($urandom_range(1, 3));
        2: bif.req_addr = BASE - 64'(4 * $urandom_range(1, 8));
        3: bif.req_addr = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 8));
        4: bif.req_addr = {$urandom, $urandom};
        default: bif.req_addr = BASE + 64'(4 * $urandom_range(0, 7));
      endcase
      tick();
    end
    bif.req_valid  = 1'b0;
    load_en        = 1'b0;
    bif.resp_ready = 1'b1;
    for (c = 0; c < 50 && expq.size() > 0; c++) tick();
    chki("drain_timeout", expq.size(), 0);
    @(negedge clk);
    chk1("final_idle", bif.resp_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words in the instruction store.
REQ-002 Parameter BASE_ADDR, default 64'h0000_0000_8000_0000, is the byte address of word 0.
REQ-003 Parameter LATENCY, default 2, range 1..4, is the number of cycles from request acceptance to the response entering the response queue.
REQ-004 Parameter QDEPTH, default 4, power of two, is the maximum number of outstanding requests (in flight plus queued).
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  the fetch request is valid.
REQ-008 req_ready  output  1  the block can accept a request this cycle.
REQ-009 req_addr  input  64  the fetch byte address (the core's pc).
REQ-010 resp_valid  output  1  the head of the response queue is valid.
REQ-011 resp_ready  input  1  the consumer accepts the response this cycle.
REQ-012 resp_inst  output  32  the fetched instruction word.
REQ-013 resp_err  output  1  the response corresponds to a misaligned or out-of-range address.
REQ-014 load_en  input  1  preload write strobe.
REQ-015 load_idx  input  $clog2(DEPTH_WORDS)  preload word index.
REQ-016 load_data  input  32  preload word.

Function
REQ-017 A request SHALL be accepted in a cycle where req_valid=1 and req_ready=1; the block SHALL accept at most one request per cycle.
REQ-018 req_ready SHALL equal (outstanding < QDEPTH) and !rst, where outstanding = requests in the delay pipe + entries in the response queue.
REQ-019 A response SHALL be retired in a cycle where resp_valid=1 and resp_ready=1; a simultaneous accept and retire SHALL leave outstanding unchanged.
REQ-020 The store SHALL be read at acceptance using index (req_addr-BASE_ADDR)>>2; the result and error flag SHALL travel through a LATENCY-stage delay pipe.
REQ-021 The response SHALL enter the FIFO response queue (QDEPTH entries) exactly LATENCY cycles after acceptance, and it SHALL be visible on resp_valid in the cycle after that at the earliest.
REQ-022 Responses SHALL be returned strictly in acceptance order.
REQ-023 If req_addr[1:0]!=0, or req_addr<BASE_ADDR, or req_addr>=BASE_ADDR+4*DEPTH_WORDS, the response SHALL have resp_err=1 and resp_inst=32'h0; otherwise resp_err=0.
REQ-024 resp_inst and resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-025 When load_en=1, load_data SHALL be written to word load_idx at the clock edge; loads SHALL never be stalled by the request path.
REQ-026 A load and an accepted read to the same word in the same cycle SHALL return the old data; a read accepted in a later cycle SHALL return the new data.
REQ-027 The credit accounting SHALL ensure that the queue never overflows, so that no response is ever dropped or duplicated.
REQ-028 The address comparison SHALL use full 64-bit unsigned arithmetic, and wrap-around of BASE_ADDR+4*DEPTH_WORDS is excluded by parameter choice.

Reset
REQ-029 While rst=1: resp_valid=0, req_ready=0, resp_err=0, resp_inst=32'h0, the delay pipe is empty, the queue pointers are 0, and outstanding=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and queued responses, and no stale response SHALL appear after release.
REQ-031 Store contents SHALL NOT be altered by reset.
REQ-032 In the first cycle after release, req_ready SHALL be 1.

Verification
REQ-033 The bench SHALL preload word 0=32'h00000413 and then request 0x80000000 with LATENCY=2 and resp_ready=1, and it SHALL check resp_valid=1 with inst=32'h00000413 and err=0 exactly 3 cycles after acceptance.
REQ-034 With resp_ready=0, the bench SHALL issue back-to-back requests for words 0..5 and SHALL check that req_ready drops after 4 acceptances; it SHALL then raise resp_ready and check in-order data and that words 4 and 5 are later accepted.
REQ-035 The bench SHALL request 0x80000002, 0x7FFFFFFC and 0x80001000 (DEPTH_WORDS=1024), and it SHALL check each response is err=1 with inst=32'h0.
REQ-036 The bench SHALL perform load word 3=32'hAAAA0001 in the same cycle as a read of 0x8000000C whose old value is 32'h00000013, and it SHALL check that the response is 32'h00000013; the next read of that address SHALL return 32'hAAAA0001.
REQ-037 The bench SHALL assert rst while 3 requests are outstanding and check resp_valid=0 immediately, SHALL check req_ready=1 after release, and SHALL check that no response appears without a new request.
REQ-038 The bench SHALL hold resp_ready=1 with continuous requests and check one response per cycle at steady state with outstanding constant.
